// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared constants and FSM state type for the period meter
package period_meter_pkg;

   // System clock the period counts are expressed in
   localparam int SYS_CLK_HZ = 50_000_000;

   // Default counter width and stall limit (1 ms at 50 MHz)
   localparam int CNT_W_DEFAULT   = 16;
   localparam int TIMEOUT_DEFAULT = 50000;

   // Measurement FSM: IDLE while disabled, ARM waiting for a first edge, MEAS counting
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } state_t;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with rising-edge detector for asynchronous inputs
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q_sync,
   output logic rise
);

   logic s1;
   logic s2;
   logic prev;

   // Two metastability flops followed by a history flop for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= d;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign q_sync = s2;
   assign rise   = s2 & ~prev;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - rising-edge period meter with stall timeout; PERIOD_METER_AVG_EN enables 4-sample averaging
module period_meter
   import period_meter_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic             valid,
   output logic             stalled
);

   // Last count value before the stall is declared
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] meas;
   logic             rise;
   logic             sig_sync_unused;
   logic             terminal;
   logic             meas_done;
   logic             meas_timeout;
   logic             report;
   logic [CNT_W-1:0] report_value;

   edge_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (sig_in),
      .q_sync (sig_sync_unused),
      .rise   (rise)
   );

   // Counter holds cycles since the last edge minus one, so the period is counter+1
   assign meas         = counter + CNT_ONE;
   assign terminal     = (counter == TERM_CNT);
   assign meas_done    = enable && (state == MEAS) && rise;
   assign meas_timeout = enable && (state == MEAS) && !rise && terminal;

`ifdef PERIOD_METER_AVG_EN
   logic [CNT_W+1:0] acc;
   logic [CNT_W+1:0] acc_next;
   logic [1:0]       samples;

   // Running sum including the measurement completing this cycle
   assign acc_next     = acc + {2'b00, meas};
   assign report       = meas_done && (samples == 2'd3);
   assign report_value = acc_next[CNT_W+1:2];

   // Accumulate four periods, restart after each average or on stall/disable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         samples <= 2'd0;
      end else if (!enable || meas_timeout) begin
         acc     <= '0;
         samples <= 2'd0;
      end else if (meas_done) begin
         samples <= samples + 2'd1;
         if (samples == 2'd3) begin
            acc <= '0;
         end else begin
            acc <= acc_next;
         end
      end
   end
`else
   assign report       = meas_done;
   assign report_value = meas;
`endif

   // Next state: disable always wins; re-enable always passes through ARM
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = ARM;
            ARM:     if (rise) state_nxt = MEAS;
            MEAS:    if (!rise && terminal) state_nxt = ARM;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Period counter: runs only in MEAS, restarts on every edge or stall, never wraps
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter <= '0;
      end else if (!enable || (state != MEAS) || meas_done || meas_timeout) begin
         counter <= '0;
      end else begin
         counter <= meas;
      end
   end

   // Result registers: a rise beats the terminal count; disable freezes period_out and stalled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_out <= '0;
         valid      <= 1'b0;
         stalled    <= 1'b0;
      end else begin
         valid <= report || meas_timeout;
         if (meas_timeout) begin
            period_out <= '0;
            stalled    <= 1'b1;
         end else begin
            if (report) begin
               period_out <= report_value;
            end
            if (meas_done) begin
               stalled <= 1'b0;
            end
         end
      end
   end

endmodule
